// File: rtl/square_pixel_renderer.sv
// RGB565 colour stage for the 96x64 OLED: draws the latched square, the fixed wall and background.
// Latency: 3 clocks from a pixel_index change to oled_data (A input reg, B scan tracker, C colour reg).
module square_pixel_renderer #(
  parameter int unsigned SQ_SIZE     = 9,
  parameter int unsigned WALL_X      = 65,
  parameter int unsigned WALL_Y      = 30,
  parameter logic [15:0] SQ_COLOUR   = 16'h07E0,
  parameter logic [15:0] WALL_COLOUR = 16'hFFFF,
  parameter logic [15:0] BG_COLOUR   = 16'h0000
) (
  input  logic        clock_25Mhz,
  input  logic        reset_n,
  input  logic [12:0] pixel_index,
  input  logic [6:0]  current_x,
  input  logic [5:0]  current_y,
  input  logic        switch,
  output logic [15:0] oled_data,
  output logic        frame_start
);

  localparam logic [6:0] LastCol = 7'd95;
  localparam logic [5:0] LastRow = 6'd63;
  localparam logic [5:0] OffY    = 6'd54;

  logic [12:0] r_idx_q;
  logic [12:0] r_idx_d;
  logic [6:0]  r_col;
  logic [5:0]  r_row;
  logic        r_sync;
  logic [6:0]  r_lx;
  logic [5:0]  r_ly;
  logic [15:0] r_oled_data;
  logic        r_frame_start;

  logic        w_evt;
  logic        w_next;
  logic [7:0]  w_x_hi;
  logic [6:0]  w_y_hi;
  logic        w_in_sq;
  logic        w_in_wall;

  // idx_d resets to an impossible index so that a first index of 0 is still seen as a change
  always_ff @(posedge clock_25Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_idx_q <= 13'd0;
      r_idx_d <= 13'h1FFF;
    end else begin
      r_idx_q <= pixel_index;
      r_idx_d <= r_idx_q;
    end
  end

  assign w_evt  = (r_idx_q != r_idx_d);
  assign w_next = (r_idx_q == r_idx_d + 13'd1);

  always_ff @(posedge clock_25Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_col         <= 7'd0;
      r_row         <= 6'd0;
      r_sync        <= 1'b0;
      r_lx          <= 7'd0;
      r_ly          <= OffY;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_evt) begin
        if (r_idx_q == 13'd0) begin
          r_col         <= 7'd0;
          r_row         <= 6'd0;
          r_sync        <= 1'b1;
          r_frame_start <= 1'b1;
          if (switch) begin
            r_lx <= current_x;
            r_ly <= current_y;
          end else begin
            r_lx <= 7'd0;
            r_ly <= OffY;
          end
        end else if (w_next) begin
          if (r_col == LastCol) begin
            r_col <= 7'd0;
            r_row <= r_row + 6'd1;
            if (r_row == LastRow) r_sync <= 1'b0;
          end else begin
            r_col <= r_col + 7'd1;
          end
        end else begin
          r_sync <= 1'b0;
        end
      end
    end
  end

  // Widened bounds: a square near the right/bottom edge clips instead of wrapping to col/row 0
  assign w_x_hi    = {1'b0, r_lx} + 8'(SQ_SIZE - 1);
  assign w_y_hi    = {1'b0, r_ly} + 7'(SQ_SIZE - 1);
  assign w_in_sq   = ({1'b0, r_col} >= {1'b0, r_lx}) && ({1'b0, r_col} <= w_x_hi) &&
                     ({1'b0, r_row} >= {1'b0, r_ly}) && ({1'b0, r_row} <= w_y_hi);
  assign w_in_wall = (r_col >= 7'(WALL_X)) && (r_row < 6'(WALL_Y));

  always_ff @(posedge clock_25Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_oled_data <= BG_COLOUR;
    end else if (!switch || !r_sync) begin
      r_oled_data <= BG_COLOUR;
    end else if (w_in_sq) begin
      r_oled_data <= SQ_COLOUR;
    end else if (w_in_wall) begin
      r_oled_data <= WALL_COLOUR;
    end else begin
      r_oled_data <= BG_COLOUR;
    end
  end

  assign oled_data   = r_oled_data;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_square_pixel_renderer.sv
// Bench for square_pixel_renderer: table vectors, directed frame sweeps and random index streams vs a reference model.
module tb_square_pixel_renderer;

  logic        clock_25Mhz = 1'b0;
  logic        reset_n;
  logic [12:0] pixel_index;
  logic [6:0]  current_x;
  logic [5:0]  current_y;
  logic        switch;
  logic [15:0] oled_data;
  logic        frame_start;

  localparam logic [15:0] GRN = 16'h07E0;
  localparam logic [15:0] WHT = 16'hFFFF;
  localparam logic [15:0] BLK = 16'h0000;

  always #5 clock_25Mhz = ~clock_25Mhz;

  square_pixel_renderer dut (
    .clock_25Mhz (clock_25Mhz),
    .reset_n     (reset_n),
    .pixel_index (pixel_index),
    .current_x   (current_x),
    .current_y   (current_y),
    .switch      (switch),
    .oled_data   (oled_data),
    .frame_start (frame_start)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame position comes straight from the index (div/mod), valid only while
  // every index since the last 0 has been consecutive and inside the 96x64 screen.
  bit m_sync;
  int m_prev;
  int m_lx;
  int m_ly;

  typedef struct {
    int          idx;
    logic [15:0] col;
    bit          fs;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s idx=%0d got=%h expected=%h", name, pixel_index, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_colour(input bit sy, input int idx, input int lx,
                                             input int ly, input bit sw);
    int c;
    int r;
    if (!sw || !sy) return BLK;
    c = idx % 96;
    r = idx / 96;
    if (c >= lx && c <= lx + 8 && r >= ly && r <= ly + 8) return GRN;
    if (c >= 65 && r < 30) return WHT;
    return BLK;
  endfunction

  task automatic model_reset();
    m_sync = 1'b0;
    m_prev = 8191;
    m_lx   = 0;
    m_ly   = 54;
  endtask

  task automatic model_step(input int idx, output bit fs);
    fs = 1'b0;
    if (idx != m_prev) begin
      if (idx == 0) begin
        m_sync = 1'b1;
        fs     = 1'b1;
        if (switch) begin
          m_lx = int'(current_x);
          m_ly = int'(current_y);
        end else begin
          m_lx = 0;
          m_ly = 54;
        end
      end else if (!(idx == (m_prev + 1) % 8192 && idx < 6144)) begin
        m_sync = 1'b0;
      end
    end
    m_prev = idx;
  endtask

  // Present one index for 4 clocks; entered and left #1 after a rising edge.
  task automatic step(input int idx, output logic [15:0] got);
    logic [15:0] old_exp;
    bit          efs;
    old_exp = ref_colour(m_sync, m_prev, m_lx, m_ly, switch);
    model_step(idx, efs);
    pixel_index = 13'(idx);
    @(posedge clock_25Mhz);
    @(posedge clock_25Mhz);
    #1;
    chk("frame_start", {15'd0, frame_start}, {15'd0, efs});
    chk("colour_before_edge3", oled_data, old_exp);
    @(posedge clock_25Mhz);
    #1;
    got = oled_data;
    chk("colour", got, ref_colour(m_sync, m_prev, m_lx, m_ly, switch));
    chk("frame_start_width", {15'd0, frame_start}, 16'd0);
    @(posedge clock_25Mhz);
    #1;
  endtask

  task automatic sweep(input int from, input int to, input int clo, input int chi,
                       output int n_sq, output int n_wall, output int n_col0, output int n_nz);
    logic [15:0] got;
    n_sq = 0; n_wall = 0; n_col0 = 0; n_nz = 0;
    for (int i = from; i <= to; i++) begin
      step(i, got);
      if (got == GRN && (i % 96) >= clo && (i % 96) <= chi) n_sq++;
      if (got == WHT) n_wall++;
      if (got != BLK && (i % 96) == 0) n_col0++;
      if (got != BLK) n_nz++;
    end
  endtask

  initial begin
    logic [15:0] got;
    bit          dummy;
    int          a_sq, a_wall, a_c0, a_nz;
    int          b_sq, b_wall, b_c0, b_nz;
    int          cur;
    int          nxt;
    int          r;

    tbl[0]  = '{3,   BLK, 1'b0};
    tbl[1]  = '{0,   GRN, 1'b1};
    tbl[2]  = '{1,   GRN, 1'b0};
    tbl[3]  = '{2,   GRN, 1'b0};
    tbl[4]  = '{500, BLK, 1'b0};
    tbl[5]  = '{501, BLK, 1'b0};
    tbl[6]  = '{193, BLK, 1'b0};
    tbl[7]  = '{70,  BLK, 1'b0};
    tbl[8]  = '{0,   GRN, 1'b1};
    tbl[9]  = '{1,   GRN, 1'b0};
    tbl[10] = '{2,   GRN, 1'b0};
    tbl[11] = '{3,   GRN, 1'b0};
    tbl[12] = '{4,   GRN, 1'b0};
    tbl[13] = '{5,   GRN, 1'b0};
    tbl[14] = '{6,   GRN, 1'b0};
    tbl[15] = '{7,   GRN, 1'b0};
    tbl[16] = '{8,   GRN, 1'b0};
    tbl[17] = '{8,   GRN, 1'b0};
    tbl[18] = '{9,   BLK, 1'b0};
    tbl[19] = '{10,  BLK, 1'b0};

    reset_n     = 1'b0;
    pixel_index = 13'd0;
    current_x   = 7'd0;
    current_y   = 6'd0;
    switch      = 1'b1;
    repeat (3) @(posedge clock_25Mhz);
    #1;
    chk("reset_oled", oled_data, BLK);
    chk("reset_frame_start", {15'd0, frame_start}, 16'd0);
    // Releasing reset with idx_q=0 against the invalid idx_d is itself an index-0 event.
    reset_n = 1'b1;
    model_reset();
    model_step(0, dummy);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].idx, got);
      chk("table_colour", got, tbl[i].col);
      if (tbl[i].fs) chk("table_fs_seen", got, GRN);
    end

    // Asynchronous reset while frame_start is high and a green pixel is showing.
    step(0, got);
    step(1, got);
    pixel_index = 13'd0;
    model_step(0, dummy);
    @(posedge clock_25Mhz);
    @(posedge clock_25Mhz);
    #1;
    chk("pre_reset_fs", {15'd0, frame_start}, 16'd1);
    chk("pre_reset_oled", oled_data, GRN);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_oled", oled_data, BLK);
    chk("async_reset_fs", {15'd0, frame_start}, 16'd0);
    @(posedge clock_25Mhz);
    #1;
    current_x = 7'd20;
    current_y = 6'd20;
    reset_n   = 1'b1;
    model_reset();
    model_step(0, dummy);
    step(5, got);
    chk("after_reset_idx5", got, BLK);

    current_x = 7'd10;
    current_y = 6'd20;
    sweep(0, 6143, 10, 18, a_sq, a_wall, a_c0, a_nz);
    chk("full_square_px", 16'(a_sq), 16'd81);
    chk("full_wall_px", 16'(a_wall), 16'd930);
    chk("full_total_px", 16'(a_nz), 16'd1011);
    step(6144, got);
    chk("overrun_blank", got, BLK);

    current_y = 6'd31;
    sweep(0, 2999, 10, 18, a_sq, a_wall, a_c0, a_nz);
    current_x = 7'd40;
    current_y = 6'd2;
    sweep(3000, 3839, 10, 18, b_sq, b_wall, b_c0, b_nz);
    chk("move_old_frame_x10", 16'(a_sq + b_sq), 16'd81);
    sweep(0, 1055, 40, 48, a_sq, a_wall, a_c0, a_nz);
    chk("move_new_frame_x40", 16'(a_sq), 16'd81);
    chk("move_new_frame_wall", 16'(a_wall), 16'd341);

    current_x = 7'd90;
    current_y = 6'd40;
    sweep(0, 4704, 90, 95, a_sq, a_wall, a_c0, a_nz);
    chk("clip_square_px", 16'(a_sq), 16'd54);
    chk("clip_col0_dark", 16'(a_c0), 16'd0);
    switch = 1'b0;
    sweep(4705, 4760, 0, 95, a_sq, a_wall, a_c0, a_nz);
    chk("switch_off_dark", 16'(a_nz), 16'd0);
    sweep(0, 50, 0, 95, a_sq, a_wall, a_c0, a_nz);
    chk("switch_off_frame_dark", 16'(a_nz), 16'd0);
    switch = 1'b1;
    sweep(51, 5960, 0, 8, a_sq, a_wall, a_c0, a_nz);
    chk("switch_default_square", 16'(a_sq), 16'd81);
    chk("switch_default_wall", 16'(a_wall), 16'd930);

    cur = 0;
    step(0, got);
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 9) begin
        switch    = 1'($urandom_range(0, 1));
        current_x = 7'($urandom_range(0, 127));
        current_y = 6'($urandom_range(0, 63));
      end
      if (r == 6)      nxt = cur;
      else if (r == 7) nxt = int'($urandom_range(0, 6200));
      else if (r == 8) nxt = 0;
      else             nxt = (cur >= 6144) ? 0 : cur + 1;
      step(nxt, got);
      cur = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/square_pixel_renderer.md
# square_pixel_renderer

Pixel-colour stage directly downstream of the green-square mover on the 96x64 OLED. It consumes the mover's square position (`current_x`, `current_y`) and the OLED driver's `pixel_index`, and produces the 16-bit RGB565 `oled_data` for the pixel currently being scanned. The square position is latched once per frame so the square never tears mid-frame. Column and row are tracked incrementally, so no divider is needed. The block also renders the fixed wall region the mover avoids.

## Interface
- `SQ_SIZE`, 9: square edge in pixels; the square covers `[x, x+SQ_SIZE-1]` by `[y, y+SQ_SIZE-1]`.
- `WALL_X`, 65: first wall column.
- `WALL_Y`, 30: wall covers rows `0..WALL_Y-1`.
- `SQ_COLOUR`, 16'h07E0: green.
- `WALL_COLOUR`, 16'hFFFF: white.
- `BG_COLOUR`, 16'h0000: black.
- `clock_25Mhz  in  1`: the single clock; all state is on its rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `pixel_index  in  13`: OLED scan index `0..6143`, row-major, 96 columns.
- `current_x  in  7`: square left column from the mover.
- `current_y  in  6`: square top row from the mover.
- `switch  in  1`: block enable, the same switch that gates the mover.
- `oled_data  out  16`: RGB565 colour for the current pixel.
- `frame_start  out  1`: one-cycle pulse when index 0 is accepted.

## Operation
- Stage A, input register:
  - `idx_q <= pixel_index`; `idx_d <= idx_q`.
  - An index event occurs in any cycle where `idx_q != idx_d`.
- Stage B, scan tracker, acting on an index event:
  - **`idx_q == 0`:**
    - Set `col=0`, `row=0`, `sync=1`.
    - Pulse `frame_start`.
    - Latch `lx<=current_x`, `ly<=current_y`; when `switch=0`, latch `lx=0`, `ly=54` instead.
  - **`idx_q == idx_d+1`:** advance `col`.
    - At `col==95`, wrap to `col=0` and increment `row`.
    - At `row==63 && col==95`, clear `sync`; this is an overrun.
  - **Any other jump:** clear `sync`. The tracker stays desynchronised until the next index 0.
  - With no index event, the tracker holds.
- Stage C, colour register (every cycle):
  - If `!switch || !sync`: `BG_COLOUR`.
  - Else if `col` is in `[lx, lx+SQ_SIZE-1]` and `row` is in `[ly, ly+SQ_SIZE-1]`: `SQ_COLOUR`.
  - Else if `col>=WALL_X && row<WALL_Y`: `WALL_COLOUR`.
  - Else: `BG_COLOUR`.
- Width rule: the square bound comparisons use 8-bit column and 7-bit row sums, so `lx+8` and `ly+8` do not wrap. A square overhanging the right or bottom edge is clipped, not wrapped.
- Priority: square over wall over background.
- `switch` is combinational in stage C. Dropping `switch` blanks output at the next stage-C register update, and the tracker keeps running.

## Timing
- Reset values:
  - `idx_q=0`, `idx_d=13'h1FFF`. `idx_d` is deliberately invalid so that a first index of 0 counts as an event.
  - `col=0`, `row=0`, `sync=0`.
  - `lx=0`, `ly=54`.
  - `oled_data=16'h0000`, `frame_start=0`.
- Latency: `oled_data` for a new `pixel_index` is valid after the 3rd rising edge following the index change (A, B, C). `pixel_index` must be held at least 4 clocks; the OLED driver holds it 4 or more.
- `frame_start` is high for exactly the one cycle in which stage B processes index 0.
- The position latch is updated only at index 0. Changes to `current_x`/`current_y` mid-frame take effect from the next frame.
- Asynchronous reset mid-frame: all state is forced to its reset value immediately. Output is background until the next index 0.
- A repeated identical index is not an event, so no double-advance occurs.

## Test plan
- **Reset:** assert `reset_n=0` mid-scan -> `oled_data=0` and `frame_start=0` at once. After release, index 5 is presented -> output stays 0 (`sync=0`).
- **Full frame:** `switch=1`, `current_x=10`, `current_y=20`, sweep 0..6143 holding each index 4 clocks. Required result:
  - `oled_data=07E0` for cols 10..18, rows 20..28.
  - `FFFF` for cols 65..95, rows 0..29.
  - `0000` elsewhere.
  - Each value appears 3 edges after its index.
- **Mid-frame move:** change `current_x` from 10 to 40 at index 3000 -> the rest of the frame still draws at x=10. The next frame draws at cols 40..48, with `frame_start` pulsing once.
- **Index jump:** sequence 0,1,2,500 -> from index 500 the output is `0000` until index 0 recurs, after which normal colours resume.
- **Switch off:** `switch=0` during a sweep -> all output `0000`. At the next index 0 the latch becomes (0,54). After `switch=1`, the next frame draws the square at cols 0..8, rows 54..62.
- **Right-edge clip:** `current_x=90`, `current_y=40` -> cols 90..95 are green on rows 40..48. Col 0 on rows 41..49 is black (no wrap).
